// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared MD-unit definitions: opcodes, latencies, state encoding
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 4;

    // Operations that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(md_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath returning {hi, lo}
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;

    assign a_sx = {{32{a[31]}}, a};
    assign b_sx = {{32{b[31]}}, b};

    always_comb begin
        res = '0;
        case (op)
            OP_MULT:  res = a_sx * b_sx;
            OP_MULTU: res = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                // Zero divisor and the single overflowing quotient get fixed results.
                if (b == 32'h0)
                    res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'h0, 32'h8000_0000};
                else
                    res = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            OP_DIVU: begin
                if (b == 32'h0)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {a % b, a / b};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO sequencing, busy timing and stall request for the MD unit
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  md_op_t      e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      calc_res;
    logic             start;

    mdu_calc u_calc (
        .op  (e_op),
        .a   (e_a),
        .b   (e_b),
        .res (calc_res)
    );

    assign start = e_valid & is_long_op(e_op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (e_valid) begin
                    case (e_op)
                        OP_MULT, OP_MULTU: begin
                            pend_d  = calc_res;
                            cnt_d   = MUL_CNT;
                            state_d = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d  = calc_res;
                            cnt_d   = DIV_CNT;
                            state_d = ST_BUSY;
                        end
                        OP_MTHI: hi_d = e_a;
                        OP_MTLO: lo_d = e_a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // Requests arriving while busy are dropped; only the countdown advances.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    {hi_d, lo_d} = pend_q;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_BUSY);
    assign md_stall = d_md_use & (busy | start);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_rdata = (e_op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl with directed vectors
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    md_op_t      e_op;
    logic [31:0] e_a, e_b;
    logic        d_md_use;
    logic        busy, md_stall;
    logic [31:0] hi, lo, md_rdata;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   run   = 0;
    int   proto_cnt = 0;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_op     (e_op),
        .e_a      (e_a),
        .e_b      (e_b),
        .d_md_use (d_md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .md_rdata (md_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a busy period ending while out of reset is a writeback to score.
    always @(negedge clk) begin
        if (!reset) begin
            run = 0;
        end else begin
            if (busy && e_valid) begin
                proto_cnt++;
                $display("protocol error flagged: e_valid while busy (op %0d)", e_op);
            end
            if (busy) begin
                run++;
            end else if (run > 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_writeback", 32'(run), 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("busy_len", 32'(run), 32'(x.lat));
                    check("wb_hi", hi, x.hi);
                    check("wb_lo", lo, x.lo);
                end
                run = 0;
            end
        end
    end

    // Called at posedge+1 with the unit idle; holds the request for one cycle.
    task automatic issue(md_op_t op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] hi_e, logic [31:0] lo_e, int lat);
        exp_t x;
        x.hi = hi_e; x.lo = lo_e; x.lat = lat;
        sb.push_back(x);
        e_valid = 1'b1; e_op = op; e_a = a; e_b = b;
        @(posedge clk); #1;
        e_valid = 1'b0; e_op = OP_MFLO;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; e_valid = 1'b1; e_op = OP_MULT; e_a = '0; e_b = '0; d_md_use = 1'b1;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall_start", 32'(md_stall), 32'd1);
        e_op = OP_MFHI; #1;
        check("rst_stall_mfhi", 32'(md_stall), 32'd0);
        e_valid = 1'b0; d_md_use = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Accept in the first cycle after reset release.
        reset = 1'b1;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        wait_idle();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_idle();
        issue(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10);
        wait_idle();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        wait_idle();
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10);
        wait_idle();
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle();
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
        wait_idle();
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5);
        wait_idle();
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5);
        wait_idle();

        // Stall held across accept and the whole busy window.
        d_md_use = 1'b1;
        sb.push_back('{32'h0, 32'd42, 5});
        e_valid = 1'b1; e_op = OP_MULT; e_a = 32'd6; e_b = 32'd7;
        @(negedge clk);
        check("stall_accept", 32'(md_stall), 32'd1);
        @(posedge clk); #1;
        e_valid = 1'b0; e_op = OP_MFLO;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_busy", 32'(md_stall), 32'd1);
        end
        @(negedge clk);
        check("stall_after", 32'(md_stall), 32'd0);
        d_md_use = 1'b0;
        @(posedge clk); #1;

        // Move-to and move-from.
        e_valid = 1'b1; e_op = OP_MTHI; e_a = 32'h1234_5678;
        @(posedge clk); #1;
        e_valid = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'd0);
        e_op = OP_MFHI; #1;
        check("mfhi_rdata", md_rdata, 32'h1234_5678);
        e_valid = 1'b1; e_op = OP_MTLO; e_a = 32'hCAFE_BABE;
        @(posedge clk); #1;
        e_valid = 1'b1; e_op = OP_MFLO;
        @(posedge clk); #1;
        e_valid = 1'b0;
        check("mtlo_lo", lo, 32'hCAFE_BABE);
        check("mflo_rdata", md_rdata, 32'hCAFE_BABE);
        check("mf_hi_kept", hi, 32'h1234_5678);

        // Back-to-back: second request during busy must be dropped.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 5);
        e_valid = 1'b1; e_op = OP_MULT; e_a = 32'd2; e_b = 32'd3;
        @(posedge clk); #1;
        e_valid = 1'b0; e_op = OP_MFLO;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("b2b_no_second_busy", 32'(busy), 32'd0);
        check("b2b_hi", hi, 32'hFFFF_FFFE);
        check("b2b_lo", lo, 32'd1);
        check("protocol_errors", 32'(proto_cnt), 32'd1);

        // Reset in busy cycle 4 of a divide aborts it.
        e_valid = 1'b1; e_op = OP_DIV; e_a = 32'd9; e_b = 32'd2;
        @(posedge clk); #1;
        e_valid = 1'b0; e_op = OP_MFLO;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_abort_hi", hi, 32'h0);
        check("post_abort_lo", lo, 32'h0);
        check("post_abort_busy", 32'(busy), 32'd0);

        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
